// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   state_t      : fetch FSM state (BOOT, RUN, HALT)
//   ECALL_INSTR  : encoding that stops fetch
//   DEF_*        : default widths and reset PC used by the fetch blocks
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          DEF_ADDR_W   = 6;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [5:0]  DEF_RESET_PC = 6'h00;

    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Fetch-to-decode handshake bundle.
//   out_valid : fetch -> decode, FIFO head is valid
//   out_ready : decode -> fetch, decode accepts the head
//   out_instr : fetch -> decode, head instruction
//   out_pc    : fetch -> decode, head PC (word address)
//
// Handshake: a transfer happens on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid is 1 and no transfer has happened,
// out_instr/out_pc stay stable unless a redirect or reset flushes the queue.
// out_ready may depend on nothing from fetch; out_valid never depends on
// out_ready.
//
// Modports: master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface : instr_fetch_unit_if

// File: rtl/fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry FIFO of {pc, instr} pairs. Entry 0 is always the head, so the
// head outputs come straight from registers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enq, enq_pc/instr   : push (caller guarantees space)
//   deq                 : pop the head (caller guarantees non-empty)
//   flush               : discard all entries; wins over enq/deq
//   head_valid/pc/instr : head entry
//   count               : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_fifo2 #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic [ADDR_W-1:0] enq_pc,
    input  logic [DATA_W-1:0] enq_instr,
    input  logic              deq,
    input  logic              flush,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] head_pc_q,    head_pc_d;
    logic [DATA_W-1:0] head_instr_q, head_instr_d;
    logic [ADDR_W-1:0] tail_pc_q,    tail_pc_d;
    logic [DATA_W-1:0] tail_instr_q, tail_instr_d;
    logic [1:0]        count_q,      count_d;

    always_comb begin
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        count_d      = count_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({enq, deq})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = enq_pc;
                        head_instr_d = enq_instr;
                        count_d      = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_pc_d    = enq_pc;
                        tail_instr_d = enq_instr;
                        count_d      = 2'd2;
                    end
                end
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    // Full: shift tail up, new word becomes tail.
                    // One entry: new word replaces the head directly.
                    if (count_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = enq_pc;
                        tail_instr_d = enq_instr;
                    end else begin
                        head_pc_d    = enq_pc;
                        head_instr_d = enq_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
            count_q      <= 2'd0;
        end else begin
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            count_q      <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_pc    = head_pc_q;
    assign head_instr = head_instr_q;
    assign count      = count_q;

endmodule : fetch_fifo2

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, reads a combinational instruction memory and queues
// {pc, instr} pairs for decode in a 2-entry FIFO. Supports redirect and
// stops fetching after an ECALL.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : word address to instruction memory (= PC register)
//   imem_data       : instruction at imem_addr, same cycle
//   redirect_valid  : load redirect_addr into the PC this cycle
//   redirect_addr   : new PC
//   out_if          : decode handshake (out_valid/out_ready/out_instr/out_pc)
//   halted          : fetch stopped after ECALL
//   dbg_state       : current FSM state
//   fetch_count     : enqueue counter, saturating (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [DATA_W-1:0]    imem_data,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_addr,
    instr_fetch_unit_if.master   out_if,
    output logic                 halted,
    output state_t               dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          fetch_count
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    logic              enq;
    logic              deq;
    logic              flush;
    logic              space;
    logic              head_valid;
    logic [1:0]        count;

    assign deq   = head_valid && out_if.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign space = (count != 2'd2) || deq;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        enq     = 1'b0;
        flush   = 1'b0;

        unique case (state_q)
            BOOT: begin
                // Redirect is ignored until the first post-reset edge.
                state_d = RUN;
            end
            RUN, HALT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_addr;
                    state_d = RUN;
                end else if (state_q == RUN && space) begin
                    enq  = 1'b1;
                    pc_d = pc_q + 1'b1;
                    if (imem_data == ECALL_INSTR) begin
                        state_d = HALT;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq        (enq),
        .enq_pc     (pc_q),
        .enq_instr  (imem_data),
        .deq        (deq),
        .flush      (flush),
        .head_valid (head_valid),
        .head_pc    (out_if.out_pc),
        .head_instr (out_if.out_instr),
        .count      (count)
    );

    assign out_if.out_valid = head_valid;
    assign imem_addr        = pc_q;
    assign halted           = (state_q == HALT);
    assign dbg_state        = state_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (enq && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 16'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule : instr_fetch_unit
